// File: rtl/uart_bram_loader.sv
// UART (8N1) receiver that packs bytes into BRAM_WIDTH-bit words and writes a frame sequentially into a BRAM.
// Optional trailing checksum byte verification is enabled with `define LOADER_CHECKSUM_EN.
module uart_bram_loader #(
    parameter int BRAM_WIDTH = 48,
    parameter int BRAM_DEPTH = 12800,
    parameter int BAUD_RATE  = 3000000,
    parameter int CLK_FREQ   = 100000000
) (
    input  logic                                                 clk_in,
    input  logic                                                 rst_in,
    input  logic                                                 uart_rxd,
    input  logic                                                 load_start_in,
    output logic [((BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1)-1:0] addr_out,
    output logic [BRAM_WIDTH-1:0]                                data_out,
    output logic                                                 we_out,
    output logic                                                 busy_out,
    output logic                                                 done_out,
    output logic                                                 frame_err_out,
    output logic                                                 checksum_ok_out
);

    localparam int ADDR_W         = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
    localparam int BYTES_PER_WORD = BRAM_WIDTH / 8;
    localparam int BIDX_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_CHECK, L_DONE} ld_state_t;

    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_ferr_q, byte_ferr_d;

    ld_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [BRAM_WIDTH-1:0] word_q, word_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BRAM_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic                  ok_q, ok_d;
`endif

    // Receiver: a low line while idle is a falling edge, since we only return to idle once the line is high.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d    = '0;
                    byte_valid_d = rx_sync_q;
                    byte_ferr_d  = !rx_sync_q;
                    rx_state_d   = RX_WAIT_HIGH;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
            default:      rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ferr_d     = ferr_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        ok_d       = ok_q;
`endif
        if (load_start_in) begin
            state_d    = L_LOAD;
            busy_d     = 1'b1;
            word_idx_d = '0;
            byte_idx_d = '0;
            word_d     = '0;
            ferr_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = '0;
            ok_d       = 1'b0;
`endif
        end else begin
            unique case (state_q)
                L_IDLE: ;
                L_LOAD: begin
                    if (byte_ferr_q) ferr_d = 1'b1;
                    if (byte_valid_q) begin
                        word_d[byte_idx_q*8 +: 8] = shift_q;
`ifdef LOADER_CHECKSUM_EN
                        sum_d = sum_q + shift_q;
`endif
                        if (byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1)) begin
                            byte_idx_d = '0;
                            we_d       = 1'b1;
                            addr_d     = word_idx_q;
                            data_d     = word_d;
                            if (word_idx_q == ADDR_W'(BRAM_DEPTH - 1)) begin
`ifdef LOADER_CHECKSUM_EN
                                state_d = L_CHECK;
`else
                                state_d = L_DONE;
`endif
                            end else begin
                                word_idx_d = word_idx_q + 1'b1;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                L_CHECK: begin
                    // A corrupted checksum byte can never vouch for the frame.
                    if (byte_ferr_q) begin
                        ferr_d  = 1'b1;
                        ok_d    = 1'b0;
                        state_d = L_DONE;
                    end else if (byte_valid_q) begin
                        ok_d    = (shift_q == sum_q);
                        state_d = L_DONE;
                    end
                end
`endif
                L_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = L_IDLE;
                end
                default: state_d = L_IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block only.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_ferr_q  <= 1'b0;
            state_q      <= L_IDLE;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
            ok_q         <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
            rx_meta_q    <= uart_rxd;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_ferr_q  <= byte_ferr_d;
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            ok_q         <= ok_d;
`endif
        end
    end

    assign addr_out      = addr_q;
    assign data_out      = data_q;
    assign we_out        = we_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign frame_err_out = ferr_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum_ok_out = ok_q;
`else
    assign checksum_ok_out = 1'b0;
`endif

endmodule
